// File: rtl/instr_memory.sv
// Word-addressed instruction/data memory with single-word and burst (4/8/16) reads and writes.
// Reads return one word per cycle with one cycle of latency; bursts run to completion once accepted.
module instr_memory #(
  parameter logic [31:0] BaseAddr   = 32'h8002_0000,
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned AddrBits   = $clog2(DepthWords)
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        rw_i,
  input  logic [31:0] address_i,
  input  logic [1:0]  access_size_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        data_valid_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q, state_d;
  logic [AddrBits-1:0] index_q, index_d;
  logic [4:0]          nbeats_q, nbeats_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         data_out_q, data_out_d;
  logic                data_valid_q, data_valid_d;

  logic [31:0]         mem_q [DepthWords];
  logic                mem_we;
  logic [AddrBits-1:0] mem_waddr;

  logic [31:0]         offset;
  logic [AddrBits-1:0] req_index;
  logic [4:0]          req_beats;
  logic                unused_offset_bits;

  // Out-of-window addresses alias by keeping only the low index bits of the offset.
  assign offset             = address_i - BaseAddr;
  assign req_index          = offset[AddrBits+1:2];
  assign unused_offset_bits = ^{offset[31:AddrBits+2], offset[1:0]};

  always_comb begin
    case (access_size_i)
      2'b00:   req_beats = 5'd1;
      2'b01:   req_beats = 5'd4;
      2'b10:   req_beats = 5'd8;
      default: req_beats = 5'd16;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    nbeats_d     = nbeats_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = index_q + AddrBits'(cnt_q);

    case (state_q)
      StIdle: begin
        if (enable_i) begin
          index_d  = req_index;
          nbeats_d = req_beats;
          cnt_d    = 5'd0;
          if (rw_i) begin
            data_out_d   = mem_q[req_index];
            data_valid_d = 1'b1;
            if (req_beats != 5'd1) state_d = StRead;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = req_index;
            if (req_beats != 5'd1) begin
              state_d = StWrite;
              cnt_d   = 5'd1;
            end
          end
        end
      end
      StRead: begin
        // cnt_q is the beat currently on data_out_o.
        if (cnt_q == nbeats_q - 5'd1) begin
          state_d = StIdle;
        end else begin
          cnt_d        = cnt_q + 5'd1;
          data_out_d   = mem_q[index_q + AddrBits'(cnt_q + 5'd1)];
          data_valid_d = 1'b1;
        end
      end
      StWrite: begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == nbeats_q - 5'd1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      index_q      <= '0;
      nbeats_q     <= 5'd1;
      cnt_q        <= 5'd0;
      data_out_q   <= 32'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      nbeats_q     <= nbeats_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage is never cleared; writes are blocked while reset is held.
  always_ff @(posedge clock_i) begin
    if (mem_we && !reset_i) mem_q[mem_waddr] <= data_in_i;
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = (state_q != StIdle);

endmodule
